// File: rtl/round_const_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : round_const_seq_pkg
//  Description : Shared state encoding, round limit and the round-constant
//                function for the round-constant sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package round_const_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int MAX_ROUNDS = 12;

    // c[k] = {15-k, k}: the high nibble is the ones' complement of the low one.
    function automatic logic [7:0] rc(input logic [3:0] k);
        logic [3:0] hi;
        hi = 4'd15 - k;
        return {hi, k};
    endfunction

endpackage
`default_nettype wire

// File: rtl/round_const_seq_rc_xor.sv
`default_nettype none
// ============================================================================
//  Module      : rc_xor
//  Description : Combinational lane word XOR round constant c[k], with the
//                constant zero-extended to the lane width.
//  Revision    : 1.0  initial release
// ============================================================================
module rc_xor
    import round_const_seq_pkg::*;
#(
    parameter int LANE_W = 64
) (
    input  logic [LANE_W-1:0] x,
    input  logic [3:0]        k,
    output logic [LANE_W-1:0] y
);

    assign y = x ^ LANE_W'(rc(k));

endmodule
`default_nettype wire

// File: rtl/round_const_seq.sv
`default_nettype none
// ============================================================================
//  Module      : round_const_seq
//  Description : Sequences R rounds of lane-2 words through a one-deep output
//                register, XORing each with the round constant c[12-R+i].
//  Revision    : 1.0  initial release
// ============================================================================
module round_const_seq
    import round_const_seq_pkg::*;
#(
    parameter int LANE_W = 64,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  rounds,
    input  logic [LANE_W-1:0] x2_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [LANE_W-1:0] x2_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  round_idx,
    output logic              last,
    output logic              busy,
    output logic              err
);

    state_t             state;
    logic [CNT_W-1:0]   r_lat;
    logic [CNT_W-1:0]   idx;
    logic [3:0]         k;
    logic [LANE_W-1:0]  xored;
    logic               xfer;
    logic               pop;
    logic               at_last;
    logic               rounds_ok;

    // Shorter permutations use the tail of the 12-entry constant schedule.
    // k stays within 0..11 because idx never passes R-1.
    assign k         = 4'(MAX_ROUNDS) - r_lat[3:0] + idx[3:0];
    assign at_last   = (idx == r_lat - CNT_W'(1));
    assign rounds_ok = (rounds != '0) && (rounds <= CNT_W'(MAX_ROUNDS));

    assign in_ready  = (state == RUN) && (!out_valid || out_ready);
    assign busy      = (state != IDLE);
    assign xfer      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    rc_xor #(
        .LANE_W (LANE_W)
    ) u_rc_xor (
        .x (x2_in),
        .k (k),
        .y (xored)
    );

    // Sequencing FSM plus the output register; a pop and a new transfer in the
    // same cycle simply overwrite the register so there is no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            r_lat     <= '0;
            idx       <= '0;
            x2_out    <= '0;
            out_valid <= 1'b0;
            round_idx <= '0;
            last      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (rounds_ok) begin
                            r_lat <= rounds;
                            idx   <= '0;
                            err   <= 1'b0;
                            state <= RUN;
                        end else begin
                            err   <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (xfer) begin
                        x2_out    <= xored;
                        out_valid <= 1'b1;
                        round_idx <= idx + CNT_W'(1);
                        last      <= at_last;
                        if (at_last) begin
                            state <= DRAIN;
                        end else begin
                            idx   <= idx + CNT_W'(1);
                        end
                    end else if (pop) begin
                        out_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (pop) begin
                        out_valid <= 1'b0;
                        if (last) begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_round_const_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_round_const_seq
//  Description : Scoreboard bench for round_const_seq; a 64-bit and a 32-bit
//                instance run in lockstep from the same stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_round_const_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [4:0]  rounds;
    logic [63:0] x2_in;
    logic        in_valid;
    logic        out_ready;

    logic        in_ready,  out_valid,  last,  busy,  err;
    logic [63:0] x2_out;
    logic [4:0]  round_idx;

    logic        in_ready32, out_valid32, last32, busy32, err32;
    logic [31:0] x2_out32;
    logic [4:0]  round_idx32;

    typedef struct packed {
        logic [63:0] x;
        logic [4:0]  idx;
        logic        last;
    } exp_t;

    exp_t sb[$];

    // Hand-computed constant schedule c[0..11].
    logic [7:0] ctab [12] = '{8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
                              8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    logic last_popped = 1'b0;

    round_const_seq #(.LANE_W(64), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rounds(rounds),
        .x2_in(x2_in), .in_valid(in_valid), .in_ready(in_ready),
        .x2_out(x2_out), .out_valid(out_valid), .out_ready(out_ready),
        .round_idx(round_idx), .last(last), .busy(busy), .err(err)
    );

    round_const_seq #(.LANE_W(32), .CNT_W(5)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start), .rounds(rounds),
        .x2_in(x2_in[31:0]), .in_valid(in_valid), .in_ready(in_ready32),
        .x2_out(x2_out32), .out_valid(out_valid32), .out_ready(out_ready),
        .round_idx(round_idx32), .last(last32), .busy(busy32), .err(err32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every word the DUT hands over is compared with the queue head.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_word", x2_out, 64'hdead_dead_dead_dead);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("x2_out",       x2_out,             e.x);
                chk("round_idx",    64'(round_idx),     64'(e.idx));
                chk("last",         64'(last),          64'(e.last));
                chk("out_valid32",  64'(out_valid32),   64'd1);
                chk("x2_out32",     64'(x2_out32),      64'(e.x[31:0]));
                chk("round_idx32",  64'(round_idx32),   64'(e.idx));
            end
            pops++;
            if (last) last_popped = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_run(input int r, input logic [63:0] x);
        for (int i = 0; i < r; i++) begin
            exp_t e;
            e.x    = x ^ {56'b0, ctab[12 - r + i]};
            e.idx  = 5'(i + 1);
            e.last = (i == r - 1);
            sb.push_back(e);
        end
    endtask

    task automatic do_start(input int r);
        rounds = 5'(r);
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!last_popped && n < budget) begin
            tick();
            n++;
        end
        chk("done_in_budget", 64'(last_popped), 64'd1);
        chk("busy_after_pop", 64'(busy), 64'd0);
        chk("valid_after_pop", 64'(out_valid), 64'd0);
        chk("busy32_after_pop", 64'(busy32), 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic run(input int r, input logic [63:0] x, input bit stall);
        x2_in       = x;
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        last_popped = 1'b0;
        push_run(r, x);
        do_start(r);
        chk("err_after_start", 64'(err), 64'd0);
        chk("busy_after_start", 64'(busy), 64'd1);
        if (stall) begin
            out_ready = 1'b0;
            tick();
            for (int s = 0; s < 3; s++) begin
                chk("stall_valid",    64'(out_valid), 64'd1);
                chk("stall_in_ready", 64'(in_ready),  64'd0);
                chk("stall_x2_out",   x2_out, x ^ 64'h0000_0000_0000_00b4);
                chk("stall_x2_out32", 64'(x2_out32), 64'(x[31:0] ^ 32'h0000_00b4));
                chk("stall_idx",      64'(round_idx), 64'd1);
                tick();
            end
            out_ready = 1'b1;
        end
        wait_done(60);
        in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst_n = 1'b1; start = 1'b0; rounds = '0; x2_in = '0;
        in_valid = 1'b0; out_ready = 1'b0;
        #2 rst_n = 1'b0;
        tick(); tick();
        chk("rst_busy",     64'(busy),      64'd0);
        chk("rst_valid",    64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready),  64'd0);
        chk("rst_x2_out",   x2_out,         64'd0);
        chk("rst_err",      64'(err),       64'd0);
        rst_n = 1'b1;
        tick();

        // six rounds from zero: 96 87 78 69 5a 4b
        run(6, 64'd0, 1'b0);

        // twelve rounds, all-ones lane
        run(12, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

        // eight rounds with downstream stall after the first word
        run(8, 64'hA5A5_5A5A_1234_5600, 1'b1);

        // illegal round counts, then recovery with a single round
        do_start(0);
        chk("err_r0",  64'(err),  64'd1);
        chk("busy_r0", 64'(busy), 64'd0);
        do_start(13);
        chk("err_r13",   64'(err),   64'd1);
        chk("busy_r13",  64'(busy),  64'd0);
        chk("err32_r13", 64'(err32), 64'd1);
        run(1, 64'd0, 1'b0);

        // reset in the middle of a twelve-round permutation
        x2_in = 64'hFFFF_FFFF_FFFF_FFFF;
        in_valid = 1'b1; out_ready = 1'b1; last_popped = 1'b0;
        push_run(12, x2_in);
        pops = 0;
        do_start(12);
        n = 0;
        while (pops < 3 && n < 40) begin
            tick();
            n++;
        end
        chk("three_pops", 64'(pops >= 3), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_x2_out",   x2_out,          64'd0);
        chk("mid_rst_valid",    64'(out_valid),  64'd0);
        chk("mid_rst_idx",      64'(round_idx),  64'd0);
        chk("mid_rst_last",     64'(last),       64'd0);
        chk("mid_rst_busy",     64'(busy),       64'd0);
        chk("mid_rst_in_ready", 64'(in_ready),   64'd0);
        chk("mid_rst_x2_out32", 64'(x2_out32),   64'd0);
        sb.delete();
        in_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", 64'(busy), 64'd0);
        run(8, 64'd0, 1'b0);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/round_const_seq.md
ROUND_CONST_SEQ -- requirements
Module: round_const_seq

Interface
REQ-001 Parameter: LANE_W, 64, lane width in bits (8..64).
REQ-002 Parameter: CNT_W, 5, width of round count and round index.
REQ-003 Ports: clk  in  1  rising-edge clock.
REQ-004 Ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Ports: start  in  1  one-cycle pulse that begins a permutation, accepted only in IDLE.
REQ-006 Ports: rounds  in  CNT_W  requested round count, sampled on an accepted start.
REQ-007 Ports: x2_in  in  LANE_W  lane-2 word for the current round.
REQ-008 Ports: in_valid  in  1  x2_in valid.
REQ-009 Ports: in_ready  out  1  the block accepts x2_in this cycle.
REQ-010 Ports: x2_out  out  LANE_W  registered x2_in XOR round constant.
REQ-011 Ports: out_valid  out  1  x2_out valid.
REQ-012 Ports: out_ready  in  1  downstream accepts x2_out.
REQ-013 Ports: round_idx  out  CNT_W  1-based round number of the word currently in x2_out.
REQ-014 Ports: last  out  1  x2_out holds the final round's word.
REQ-015 Ports: busy  out  1  state is not IDLE.
REQ-016 Ports: err  out  1  sticky flag: a start was rejected because of an illegal rounds value.

Function
REQ-017 States SHALL be IDLE, RUN and DRAIN.
REQ-018 IDLE->RUN SHALL occur on start with 1<=rounds<=12: latch rounds as R, set i=0, clear err.
REQ-019 A start with rounds=0 or rounds>12 SHALL set err and leave the state in IDLE.
REQ-020 A start outside IDLE SHALL be ignored with no state change.
REQ-021 The constant for round i (0-based) SHALL be c[k], where k=12-R+i and c[k]={4'(15-k),4'(k)}, zero-extended to LANE_W; this gives 0xf0 for k=0 and 0x4b for k=11.
REQ-022 The constant SHALL be computed arithmetically; no per-R case table is used.
REQ-023 R=6, 8 and 12 SHALL yield the first constants 0x96, 0xb4 and 0xf0; every R from 1 to 12 is legal.
REQ-024 in_ready SHALL equal (state==RUN) && (!out_valid || out_ready).
REQ-025 A transfer (in_valid && in_ready) SHALL register x2_out=x2_in^c[k], set out_valid, set round_idx=i+1, set last=(i==R-1) and increment i. Latency is one cycle.
REQ-026 A transfer with i==R-1 SHALL move the state RUN->DRAIN.
REQ-027 When out_valid && !out_ready, x2_out, round_idx and last SHALL hold stable and in_ready SHALL be 0.
REQ-028 A simultaneous output pop and input transfer in the same cycle SHALL replace the output register with no bubble.
REQ-029 DRAIN->IDLE SHALL occur when the last word is popped (out_valid && out_ready && last); out_valid then clears.
REQ-030 An output pop with no new transfer SHALL clear out_valid.
REQ-031 The index i SHALL never exceed R-1; no wrap-around is possible.
REQ-032 Nothing SHALL be accepted in IDLE or DRAIN.

Reset
REQ-033 Asserting rst_n low SHALL immediately force state=IDLE, i=0, x2_out=0, out_valid=0, round_idx=0, last=0, busy=0, err=0 and in_ready=0.
REQ-034 Reset asserted during RUN or DRAIN SHALL discard the permutation in flight; after deassertion the block waits for a new start.

Structure
REQ-035 A shared package SHALL hold the state enum, the constant MAX_ROUNDS=12 and the function rc(k) that returns c[k].
REQ-036 One sub-module, rc_xor (combinational x^rc(k), LANE_W-parametrised), SHALL be instantiated; the sequencing FSM and the output register stay in round_const_seq.

Verification
REQ-037 Scenario: start, rounds=6, in_valid held high, out_ready=1, x2_in=0 -> six outputs 0x96, 0x87, 0x78, 0x69, 0x5a, 0x4b, round_idx 1..6, last on the sixth, busy low one cycle after the final pop.
REQ-038 Scenario: rounds=12, x2_in=0xFFFF_FFFF_FFFF_FFFF -> first output 0xFFFF_FFFF_FFFF_FF0F, last output 0xFFFF_FFFF_FFFF_FFB4.
REQ-039 Scenario: rounds=8, out_ready low for 3 cycles after the first output -> x2_out stays 0xb4^x2_in, in_ready stays 0, and no word is lost or duplicated.
REQ-040 Scenario: start with rounds=0, then rounds=13 -> err=1, busy=0; a following start with rounds=1 -> err clears and a single output 0x4b arrives with last=1.
REQ-041 Scenario: rst_n pulsed low after round 3 of 12 -> all outputs 0 at once; a new start with rounds=8 yields 0xb4 first.
REQ-042 Scenario: LANE_W=32 build, rounds=8 -> identical constants in the low byte, upper bits untouched.
